// File: rtl/ddr2_seq_bridge_pkg.sv
// Shared types and constants for the DDR2 sequencer command master.
// The optional statistics block (macro DDR2_SEQ_CMD_MASTER_STATS_EN) uses STAT_WIDTH.
package ddr2_seq_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  localparam int DEFAULT_AVL_DATA_WIDTH = 32;
  localparam int DEFAULT_AVL_ADDR_WIDTH = 16;

  // Read data reported when a transfer is abandoned under waitrequest
  localparam logic [DEFAULT_AVL_DATA_WIDTH-1:0] TIMEOUT_READDATA = '1;

  localparam int STAT_WIDTH = 16;

  // Bits needed to hold 0..max_val, never less than one
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ddr2_seq_timeout_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment)
// and a compare output that flags when the count equals HIT_VALUE.
module ddr2_seq_timeout_counter #(
  parameter int WIDTH     = 4,
  parameter int HIT_VALUE = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             hit
);

  localparam logic [WIDTH-1:0] HIT_V = WIDTH'(HIT_VALUE);

  // Count up on inc, hold at all-ones, clear has priority
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign hit = (count == HIT_V);

endmodule

// File: rtl/ddr2_sequencer_cmd_master.sv
// Avalon-MM master feeding the sequencer bridge from a valid/ready command
// stream. One transfer in flight at a time; a stuck waitrequest is aborted
// after TIMEOUT_CYCLES and reported as an error response.
// Optional transfer statistics: define DDR2_SEQ_CMD_MASTER_STATS_EN.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// ISSUE | strobe on the bus, waiting for waitrequest to drop or timeout
// RESP  | response held on rsp_* until rsp_ready
module ddr2_sequencer_cmd_master
  import ddr2_seq_bridge_pkg::*;
#(
  parameter int AVL_DATA_WIDTH = DEFAULT_AVL_DATA_WIDTH,
  parameter int AVL_ADDR_WIDTH = DEFAULT_AVL_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      avl_clk,
  input  logic                      avl_reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [AVL_ADDR_WIDTH-1:0] cmd_address,
  input  logic [AVL_DATA_WIDTH-1:0] cmd_writedata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [AVL_DATA_WIDTH-1:0] rsp_readdata,
  output logic                      rsp_error,
  output logic [AVL_ADDR_WIDTH-1:0] avl_address,
  output logic                      avl_write,
  output logic [AVL_DATA_WIDTH-1:0] avl_writedata,
  output logic                      avl_read,
  input  logic [AVL_DATA_WIDTH-1:0] avl_readdata,
  input  logic                      avl_waitrequest
`ifdef DDR2_SEQ_CMD_MASTER_STATS_EN
  ,
  input  logic                      stat_clear,
  output logic [STAT_WIDTH-1:0]     stat_rd_count,
  output logic [STAT_WIDTH-1:0]     stat_wr_count,
  output logic [STAT_WIDTH-1:0]     stat_timeout_count
`endif
);

  localparam int TMO_W   = cnt_width(TIMEOUT_CYCLES);
  localparam int TMO_HIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  seq_state_e       state;
  logic             xfer_done;
  logic             tmo_fire;
  logic             tmo_clr;
  logic             tmo_hit;
  logic [TMO_W-1:0] tmo_count_unused;

  assign cmd_ready = (state == IDLE) && !avl_reset;

  // In ISSUE the strobe is always high, so waitrequest low means completion
  assign xfer_done = (state == ISSUE) && !avl_waitrequest;
  assign tmo_fire  = (TIMEOUT_CYCLES > 0) && (state == ISSUE) && avl_waitrequest && tmo_hit;
  assign tmo_clr   = avl_reset || (state != ISSUE) || !avl_waitrequest || tmo_fire;

  ddr2_seq_timeout_counter #(
    .WIDTH     (TMO_W),
    .HIT_VALUE (TMO_HIT)
  ) u_tmo_cnt (
    .clk   (avl_clk),
    .clr   (tmo_clr),
    .inc   (avl_waitrequest),
    .count (tmo_count_unused),
    .hit   (tmo_hit)
  );

  // Command/response sequencing with registered Avalon and response outputs
  always_ff @(posedge avl_clk) begin
    if (avl_reset) begin
      state         <= IDLE;
      avl_read      <= 1'b0;
      avl_write     <= 1'b0;
      avl_address   <= '0;
      avl_writedata <= '0;
      rsp_valid     <= 1'b0;
      rsp_readdata  <= '0;
      rsp_error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            avl_address   <= cmd_address;
            avl_writedata <= cmd_writedata;
            avl_write     <= cmd_write;
            avl_read      <= !cmd_write;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (xfer_done) begin
            rsp_readdata <= avl_read ? avl_readdata : '0;
            rsp_error    <= 1'b0;
            avl_read     <= 1'b0;
            avl_write    <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else if (tmo_fire) begin
            rsp_readdata <= {AVL_DATA_WIDTH{1'b1}};
            rsp_error    <= 1'b1;
            avl_read     <= 1'b0;
            avl_write    <= 1'b0;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DDR2_SEQ_CMD_MASTER_STATS_EN
  logic stat_clr;
  logic rd_sat_unused;
  logic wr_sat_unused;
  logic to_sat_unused;

  assign stat_clr = avl_reset || stat_clear;

  ddr2_seq_timeout_counter #(.WIDTH(STAT_WIDTH), .HIT_VALUE(0)) u_stat_rd (
    .clk   (avl_clk),
    .clr   (stat_clr),
    .inc   (xfer_done && avl_read),
    .count (stat_rd_count),
    .hit   (rd_sat_unused)
  );

  ddr2_seq_timeout_counter #(.WIDTH(STAT_WIDTH), .HIT_VALUE(0)) u_stat_wr (
    .clk   (avl_clk),
    .clr   (stat_clr),
    .inc   (xfer_done && avl_write),
    .count (stat_wr_count),
    .hit   (wr_sat_unused)
  );

  ddr2_seq_timeout_counter #(.WIDTH(STAT_WIDTH), .HIT_VALUE(0)) u_stat_to (
    .clk   (avl_clk),
    .clr   (stat_clr),
    .inc   (tmo_fire),
    .count (stat_timeout_count),
    .hit   (to_sat_unused)
  );
`endif

endmodule

// File: tb/tb_ddr2_sequencer_cmd_master.sv
// Self-checking bench for ddr2_sequencer_cmd_master (TIMEOUT_CYCLES=8).
// Outcomes of each transaction are predicted from the waitrequest length.
module tb_ddr2_sequencer_cmd_master;

  localparam int T = 8;

  logic        avl_clk = 1'b0;
  logic        avl_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_address;
  logic [31:0] cmd_writedata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_readdata;
  logic        rsp_error;
  logic [15:0] avl_address;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic        avl_read;
  logic [31:0] avl_readdata;
  logic        avl_waitrequest;
`ifdef DDR2_SEQ_CMD_MASTER_STATS_EN
  logic        stat_clear;
  logic [15:0] stat_rd_count;
  logic [15:0] stat_wr_count;
  logic [15:0] stat_timeout_count;
`endif

  int checks = 0;
  int errors = 0;
  int m_rd = 0;
  int m_wr = 0;
  int m_to = 0;

  ddr2_sequencer_cmd_master #(
    .AVL_DATA_WIDTH (32),
    .AVL_ADDR_WIDTH (16),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .avl_clk         (avl_clk),
    .avl_reset       (avl_reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_address     (cmd_address),
    .cmd_writedata   (cmd_writedata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_readdata    (rsp_readdata),
    .rsp_error       (rsp_error),
    .avl_address     (avl_address),
    .avl_write       (avl_write),
    .avl_writedata   (avl_writedata),
    .avl_read        (avl_read),
    .avl_readdata    (avl_readdata),
    .avl_waitrequest (avl_waitrequest)
`ifdef DDR2_SEQ_CMD_MASTER_STATS_EN
    ,
    .stat_clear         (stat_clear),
    .stat_rd_count      (stat_rd_count),
    .stat_wr_count      (stat_wr_count),
    .stat_timeout_count (stat_timeout_count)
`endif
  );

  always #5 avl_clk = ~avl_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transaction. Called at a falling edge with the DUT idle.
  // wait_c: cycles of waitrequest=1 before release; rsp_delay: cycles of rsp_ready=0.
  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                         input int wait_c, input logic [31:0] rdata, input int rsp_delay);
    int          scnt;
    int          exp_s;
    logic        exp_err;
    logic [31:0] exp_d;
    exp_err = (wait_c >= T);
    exp_s   = exp_err ? T : wait_c + 1;
    exp_d   = exp_err ? 32'hFFFF_FFFF : (wr ? 32'h0 : rdata);

    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid       = 1'b1;
    cmd_write       = wr;
    cmd_address     = addr;
    cmd_writedata   = wdata;
    avl_waitrequest = 1'($urandom_range(0, 1));
    @(negedge avl_clk);
    // junk command that must be ignored while busy
    cmd_write     = 1'($urandom_range(0, 1));
    cmd_address   = 16'($urandom);
    cmd_writedata = $urandom;
    scnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (!(avl_read || avl_write)) break;
      scnt++;
      chk("strobe_dir", {30'd0, avl_write, avl_read}, wr ? 32'd2 : 32'd1);
      chk("addr_hold", 32'(avl_address), 32'(addr));
      chk("wdata_hold", avl_writedata, wdata);
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      avl_waitrequest = (scnt - 1 < wait_c);
      avl_readdata    = avl_waitrequest ? $urandom : rdata;
      @(negedge avl_clk);
    end
    avl_waitrequest = 1'b0;
    chk("strobe_cycles", 32'(scnt), 32'(exp_s));
    chk("rsp_valid_rise", 32'(rsp_valid), 32'd1);
    chk("rsp_error", 32'(rsp_error), 32'(exp_err));
    chk("rsp_readdata", rsp_readdata, exp_d);
    for (int i = 0; i < rsp_delay; i++) begin
      rsp_ready = 1'b0;
      @(negedge avl_clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_readdata", rsp_readdata, exp_d);
      chk("bp_rsp_error", 32'(rsp_error), 32'(exp_err));
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_no_strobe", 32'(avl_read | avl_write), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge avl_clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("cmd_ready_after", 32'(cmd_ready), 32'd1);
    if (exp_err) m_to++;
    else if (wr) m_wr++;
    else m_rd++;
  endtask

  task automatic chk_stats();
`ifdef DDR2_SEQ_CMD_MASTER_STATS_EN
    chk("stat_rd", 32'(stat_rd_count), 32'(m_rd));
    chk("stat_wr", 32'(stat_wr_count), 32'(m_wr));
    chk("stat_to", 32'(stat_timeout_count), 32'(m_to));
`endif
  endtask

  initial begin
    avl_reset       = 1'b1;
    cmd_valid       = 1'b0;
    cmd_write       = 1'b0;
    cmd_address     = '0;
    cmd_writedata   = '0;
    rsp_ready       = 1'b0;
    avl_readdata    = '0;
    avl_waitrequest = 1'b0;
`ifdef DDR2_SEQ_CMD_MASTER_STATS_EN
    stat_clear = 1'b0;
`endif
    repeat (2) @(negedge avl_clk);
    chk("rst_avl_read", 32'(avl_read), 32'd0);
    chk("rst_avl_write", 32'(avl_write), 32'd0);
    chk("rst_avl_address", 32'(avl_address), 32'd0);
    chk("rst_avl_writedata", avl_writedata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_readdata", rsp_readdata, 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    avl_reset = 1'b0;
    @(negedge avl_clk);
    chk("cmd_ready_post_rst", 32'(cmd_ready), 32'd1);
    chk_stats();

    // directed cases
    run_txn(1'b1, 16'h0040, 32'hA5A5_0001, 0, 32'h0, 0);
    run_txn(1'b0, 16'h0123, 32'h0, 5, 32'h1234_5678, 0);
    run_txn(1'b0, 16'h0200, 32'h0, 20, 32'hDEAD_BEEF, 0);
    run_txn(1'b1, 16'h0204, 32'h0BAD_F00D, 0, 32'h0, 0);
    run_txn(1'b0, 16'h0300, 32'h0, T - 1, 32'hCAFE_0007, 0);
    run_txn(1'b1, 16'h0304, 32'h5555_AAAA, T, 32'h0, 0);
    run_txn(1'b0, 16'h0400, 32'h0, 1, 32'h0F0F_F0F0, 10);
    chk_stats();

    // randomized traffic
    for (int n = 0; n < 30; n++) begin
      run_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom,
              $urandom_range(0, 10), $urandom, $urandom_range(0, 3));
    end
    chk_stats();

`ifdef DDR2_SEQ_CMD_MASTER_STATS_EN
    stat_clear = 1'b1;
    @(negedge avl_clk);
    stat_clear = 1'b0;
    m_rd = 0;
    m_wr = 0;
    m_to = 0;
    chk_stats();
    run_txn(1'b0, 16'h0500, 32'h0, 0, 32'h1111_2222, 0);
    chk_stats();
`endif

    // reset while a read is held under waitrequest
    cmd_valid       = 1'b1;
    cmd_write       = 1'b0;
    cmd_address     = 16'h0600;
    avl_waitrequest = 1'b1;
    @(negedge avl_clk);
    cmd_valid = 1'b0;
    chk("mid_read_on", 32'(avl_read), 32'd1);
    repeat (3) @(negedge avl_clk);
    avl_reset = 1'b1;
    @(negedge avl_clk);
    chk("mid_rst_read", 32'(avl_read), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    avl_reset       = 1'b0;
    avl_waitrequest = 1'b0;
    m_rd = 0;
    m_wr = 0;
    m_to = 0;
    @(negedge avl_clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge avl_clk);
    end
    chk_stats();
    run_txn(1'b1, 16'h0700, 32'h7777_0000, 2, 32'h0, 1);
    chk_stats();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
